uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter (8N1) fed by a small write FIFO.
// A memory-mapped write pushes one byte; frames go out back-to-back while bytes are queued.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] uart_wdata,
    input  logic        uart_we,
    output logic        uart_full,
    output logic        txd,
    output logic        tx_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [15:0]      baud_reg, baud_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             txd_reg, txd_next;
    logic             push, pop;
    logic             fifo_empty;
    logic             bit_end;
    logic             unused_wdata_hi;

    // Only the low byte is serialised; the upper word bits are don't-care.
    assign unused_wdata_hi = ^uart_wdata[31:8];

    assign uart_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == '0);
    assign push       = uart_we & ~uart_full;
    assign bit_end    = (baud_reg == '0);

    assign txd     = txd_reg;
    assign tx_busy = (state_reg != IDLE) | ~fifo_empty;

    // Storage array kept free of reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr_reg] <= uart_wdata[7:0];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        pop          = 1'b0;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        txd_next     = txd_reg;

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    txd_next   = 1'b0;
                    baud_next  = BAUD_LOAD;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    txd_next     = shift_reg[0];
                    baud_next    = BAUD_LOAD;
                    bit_idx_next = 3'd0;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    baud_next  = BAUD_LOAD;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        // shift_reg[1] is the next bit, i.e. bit 0 after this shift.
                        txd_next     = shift_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        txd_next   = 1'b0;
                        baud_next  = BAUD_LOAD;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            txd_reg     <= 1'b1;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            txd_reg     <= txd_next;
            count_reg   <= count_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            // A pop loads the head byte straight into the shifter (registered read).
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                shift_reg  <= fifo_mem[rd_ptr_reg];
            end else begin
                shift_reg <= shift_next;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame timing, back-to-back frames,
// FIFO full/drop, pop-edge retry, mid-frame reset and default-parameter bit width.
module tb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic [31:0] uart_wdata;
    logic        uart_we;
    logic        uart_full;
    logic        txd;
    logic        tx_busy;

    logic [31:0] uart_wdata2;
    logic        uart_we2;
    logic        uart_full2;
    logic        txd2;
    logic        tx_busy2;

    int n_checks = 0;
    int n_pass   = 0;
    logic [255:0] cap;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_wdata (uart_wdata),
        .uart_we    (uart_we),
        .uart_full  (uart_full),
        .txd        (txd),
        .tx_busy    (tx_busy)
    );

    uart_tx #(.CLKS_PER_BIT(217), .FIFO_DEPTH(16)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_wdata (uart_wdata2),
        .uart_we    (uart_we2),
        .uart_full  (uart_full2),
        .txd        (txd2),
        .tx_busy    (tx_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-16s ok   value=%0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected txd for one frame at 4 clocks/bit, earliest cycle in the MSB.
    function automatic logic [39:0] frame_pat(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] pat;
        bits = {1'b1, b, 1'b0};
        pat  = '0;
        for (int k = 0; k < 10; k++) begin
            pat = {pat[35:0], {4{bits[k]}}};
        end
        return pat;
    endfunction

    // Advance to the next falling edge and record txd.
    task automatic step();
        @(negedge clk);
        cap = {cap[254:0], txd};
    endtask

    // Five writes on consecutive edges; returns after the 5th edge with 4 bits captured.
    task automatic burst5(input logic [39:0] bytes);
        uart_we    = 1'b1;
        uart_wdata = {24'h0, bytes[39:32]};
        step();
        cap = '0;
        for (int i = 1; i < 5; i++) begin
            uart_wdata = {24'h0, bytes[(4-i)*8 +: 8]};
            step();
        end
    endtask

    int start_len;
    int frame_len;
    bit seen_high;

    initial begin
        rst_n       = 1'b0;
        uart_we     = 1'b0;
        uart_wdata  = '0;
        uart_we2    = 1'b0;
        uart_wdata2 = '0;
        cap         = '0;

        // Reset state
        repeat (3) step();
        check("rst_txd",  64'(txd), 64'(1));
        check("rst_full", 64'(uart_full), 64'(0));
        check("rst_busy", 64'(tx_busy), 64'(0));
        rst_n = 1'b1;
        step();

        // Single byte from idle
        uart_we    = 1'b1;
        uart_wdata = 32'h0000_00A5;
        step();
        uart_we = 1'b0;
        check("a5_busy_early", 64'(tx_busy), 64'(1));
        cap = '0;
        repeat (40) step();
        check("a5_frame", 64'(cap[39:0]), 64'(frame_pat(8'hA5)));
        check("a5_busy_last", 64'(tx_busy), 64'(1));
        step();
        check("a5_busy_fall", 64'(tx_busy), 64'(0));
        repeat (3) step();

        // Two writes on consecutive cycles give contiguous frames
        uart_we    = 1'b1;
        uart_wdata = 32'hABCD_0055;
        step();
        cap = '0;
        uart_wdata = 32'h0000_000F;
        step();
        uart_we = 1'b0;
        repeat (79) step();
        check("b2b_frame0", 64'(cap[79:40]), 64'(frame_pat(8'h55)));
        check("b2b_frame1", 64'(cap[39:0]),  64'(frame_pat(8'h0F)));
        step();
        check("b2b_busy_fall", 64'(tx_busy), 64'(0));
        repeat (3) step();

        // Fill the FIFO, then a write while full is dropped
        burst5({8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
        check("full_after5", 64'(uart_full), 64'(1));
        uart_wdata = 32'h0000_00EE;
        step();
        uart_we = 1'b0;
        check("full_hold", 64'(uart_full), 64'(1));
        repeat (195) step();
        check("fill_f0", 64'(cap[160 +: 40]), 64'(frame_pat(8'h11)));
        check("fill_f1", 64'(cap[120 +: 40]), 64'(frame_pat(8'h22)));
        check("fill_f2", 64'(cap[80 +: 40]),  64'(frame_pat(8'h33)));
        check("fill_f3", 64'(cap[40 +: 40]),  64'(frame_pat(8'h44)));
        check("fill_f4", 64'(cap[0 +: 40]),   64'(frame_pat(8'h55)));
        step();
        check("fill_busy_fall", 64'(tx_busy), 64'(0));
        check("fill_full_fall", 64'(uart_full), 64'(0));
        cap = '0;
        repeat (40) step();
        check("no_ee_on_line", 64'(cap[39:0]), 64'({40{1'b1}}));

        // Full FIFO with a write held across the STOP pop edge
        burst5({8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});
        uart_we = 1'b0;
        check("wrap_full", 64'(uart_full), 64'(1));
        repeat (36) step();
        check("wrap_f0", 64'(cap[39:0]), 64'(frame_pat(8'hA1)));
        cap        = '0;
        uart_we    = 1'b1;
        uart_wdata = 32'h0000_00B6;
        step();
        check("pop_edge_full", 64'(uart_full), 64'(0));
        step();
        uart_we = 1'b0;
        check("retry_full", 64'(uart_full), 64'(1));
        repeat (198) step();
        check("wrap_f1", 64'(cap[160 +: 40]), 64'(frame_pat(8'hA2)));
        check("wrap_f2", 64'(cap[120 +: 40]), 64'(frame_pat(8'hA3)));
        check("wrap_f3", 64'(cap[80 +: 40]),  64'(frame_pat(8'hA4)));
        check("wrap_f4", 64'(cap[40 +: 40]),  64'(frame_pat(8'hA5)));
        check("wrap_f5", 64'(cap[0 +: 40]),   64'(frame_pat(8'hB6)));
        step();
        check("wrap_busy_fall", 64'(tx_busy), 64'(0));
        repeat (3) step();

        // Reset during DATA bit 3 with two bytes queued; writes ignored in reset
        uart_we    = 1'b1;
        uart_wdata = 32'h0000_00C3;
        step();
        uart_wdata = 32'h0000_0012;
        step();
        uart_wdata = 32'h0000_0034;
        step();
        uart_we = 1'b0;
        repeat (15) step();
        check("bit3_txd", 64'(txd), 64'(0));
        check("bit3_busy", 64'(tx_busy), 64'(1));
        rst_n      = 1'b0;
        uart_we    = 1'b1;
        uart_wdata = 32'h0000_0077;
        step();
        check("midrst_txd",  64'(txd), 64'(1));
        check("midrst_full", 64'(uart_full), 64'(0));
        check("midrst_busy", 64'(tx_busy), 64'(0));
        rst_n   = 1'b1;
        uart_we = 1'b0;
        cap     = '0;
        repeat (60) step();
        check("post_rst_idle", 64'(cap[59:0]), 64'({60{1'b1}}));
        check("post_rst_busy", 64'(tx_busy), 64'(0));

        // Default parameters: 217-cycle bits, 2170-cycle frame
        uart_we2    = 1'b1;
        uart_wdata2 = 32'h0000_0041;
        step();
        uart_we2  = 1'b0;
        start_len = 0;
        frame_len = 0;
        seen_high = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!tx_busy2) break;
            frame_len++;
            if (!seen_high && txd2 == 1'b0) start_len++;
            else seen_high = 1'b1;
        end
        check("def_start_len", 64'(start_len), 64'(217));
        check("def_frame_len", 64'(frame_len), 64'(2170));
        check("def_txd_idle",  64'(txd2), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
